// File: rtl/mem_bist_sequencer_if.sv
// Memory request port between the BIST sequencer and the memory master.
// Request is held until a one-cycle completion pulse.
interface mem_bist_sequencer_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_done;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_bist_sequencer.sv
// Memory BIST sequencer: writes a pattern over an address range, reads it
// back and reports pass/fail, first failing location and timeout.
module mem_bist_sequencer #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1048575,
  parameter int ERR_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go_i,
  input  logic [1:0]            mode_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic                  stop_on_fail_i,
  mem_bist_sequencer_if.master  mem,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ERR_WIDTH-1:0]  err_count_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_expected_o,
  output logic [DATA_WIDTH-1:0] fail_actual_o,
  output logic                  timeout_o,
  output logic [7:0]            leds_o
);
  localparam int IW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_GAP, RD_REQ, CHECK, FINISH
  } state_e;

  state_e state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [IW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic                  stop_q, stop_d;
  logic [IW-1:0]         i_q, i_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0] fexp_q, fexp_d;
  logic [DATA_WIDTH-1:0] fact_q, fact_d;
  logic                  pass_q, pass_d;
  logic                  tout_q, tout_d;
  logic                  wrdone_q, wrdone_d;
  logic                  fin_q, fin_d;

  logic [ADDR_WIDTH-1:0] addr;
  logic [IW-1:0]         imod;
  logic [IW-1:0]         i_inc;
  logic [DATA_WIDTH-1:0] pat;
  logic                  miss;
  logic                  req, we, rd_act;

  assign addr  = base_q + i_q[ADDR_WIDTH-1:0];
  assign imod  = i_q % IW'(DATA_WIDTH);
  assign i_inc = i_q + IW'(1);
  assign miss  = rd_q != pat;

  always_comb begin
    pat = seed_q;
    unique case (mode_q)
      2'd0: pat = seed_q;
      2'd1: pat = seed_q + DATA_WIDTH'(i_q);
      2'd2: pat = DATA_WIDTH'(1) << imod;
      2'd3: pat = DATA_WIDTH'(addr) ^ seed_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    seed_d   = seed_q;
    stop_d   = stop_q;
    i_d      = i_q;
    tmo_d    = tmo_q;
    rd_d     = rd_q;
    err_d    = err_q;
    faddr_d  = faddr_q;
    fexp_d   = fexp_q;
    fact_d   = fact_q;
    pass_d   = pass_q;
    tout_d   = tout_q;
    wrdone_d = wrdone_q;
    fin_d    = fin_q;
    unique case (state_q)
      IDLE: if (go_i) begin
        mode_d   = mode_i;
        base_d   = base_addr_i;
        cnt_d    = word_count_i;
        seed_d   = seed_i;
        stop_d   = stop_on_fail_i;
        i_d      = '0;
        tmo_d    = '0;
        err_d    = '0;
        faddr_d  = '0;
        fexp_d   = '0;
        fact_d   = '0;
        pass_d   = 1'b0;
        tout_d   = 1'b0;
        wrdone_d = 1'b0;
        fin_d    = 1'b0;
        state_d  = (word_count_i == '0) ? FINISH : WR_REQ;
      end
      WR_REQ, RD_REQ: begin
        if (mem.mem_done) begin
          if (state_q == RD_REQ) rd_d = mem.mem_rdata;
          state_d = (state_q == RD_REQ) ? CHECK : WR_GAP;
        end else if (tmo_q == T_LAST) begin
          tout_d  = 1'b1;
          state_d = FINISH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WR_GAP: begin
        tmo_d = '0;
        if (i_inc == cnt_q) begin
          i_d      = '0;
          wrdone_d = 1'b1;
          state_d  = RD_REQ;
        end else begin
          i_d     = i_inc;
          state_d = WR_REQ;
        end
      end
      CHECK: begin
        tmo_d = '0;
        i_d   = i_inc;
        if (miss) begin
          err_d = (&err_q) ? err_q : err_q + ERR_WIDTH'(1);
          if (err_q == '0) begin
            faddr_d = addr;
            fexp_d  = pat;
            fact_d  = rd_q;
          end
        end
        if ((miss && stop_q) || i_inc == cnt_q) state_d = FINISH;
        else                                    state_d = RD_REQ;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Result is settled on entry so it is valid alongside the done pulse.
    if (state_d == FINISH && state_q != FINISH) begin
      fin_d  = 1'b1;
      pass_d = (err_d == '0) && !tout_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      seed_q   <= '0;
      stop_q   <= 1'b0;
      i_q      <= '0;
      tmo_q    <= '0;
      rd_q     <= '0;
      err_q    <= '0;
      faddr_q  <= '0;
      fexp_q   <= '0;
      fact_q   <= '0;
      pass_q   <= 1'b0;
      tout_q   <= 1'b0;
      wrdone_q <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      seed_q   <= seed_d;
      stop_q   <= stop_d;
      i_q      <= i_d;
      tmo_q    <= tmo_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      faddr_q  <= faddr_d;
      fexp_q   <= fexp_d;
      fact_q   <= fact_d;
      pass_q   <= pass_d;
      tout_q   <= tout_d;
      wrdone_q <= wrdone_d;
      fin_q    <= fin_d;
    end
  end

  always_comb begin
    req    = 1'b0;
    we     = 1'b0;
    rd_act = 1'b0;
    done_o = 1'b0;
    busy_o = 1'b1;
    unique case (state_q)
      IDLE:   busy_o = 1'b0;
      WR_REQ: begin req = 1'b1; we = 1'b1; end
      RD_REQ: begin req = 1'b1; rd_act = 1'b1; end
      CHECK:  rd_act = 1'b1;
      FINISH: done_o = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = pat;

  assign pass_o          = pass_q;
  assign err_count_o     = err_q;
  assign fail_addr_o     = faddr_q;
  assign fail_expected_o = fexp_q;
  assign fail_actual_o   = fact_q;
  assign timeout_o       = tout_q;
  assign leds_o = {fin_q & pass_q, tout_q, |err_q, pass_q,
                   fin_q, rd_act, wrdone_q, busy_o};
endmodule

// File: tb/tb_mem_bist_sequencer.sv
// Scoreboard bench for mem_bist_sequencer with a latency-3 memory model,
// fault injection, timeout, reset-abort and randomized runs.
module tb_mem_bist_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        go_i = 1'b0;
  logic [1:0]  mode_i = '0;
  logic [10:0] base_addr_i = '0;
  logic [11:0] word_count_i = '0;
  logic [31:0] seed_i = '0;
  logic        stop_on_fail_i = 1'b0;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [15:0] err_count_o;
  logic [10:0] fail_addr_o;
  logic [31:0] fail_expected_o, fail_actual_o;
  logic [7:0]  leds_o;

  mem_bist_sequencer_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) mif();

  mem_bist_sequencer #(
    .ADDR_WIDTH(11), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .ERR_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .go_i(go_i), .mode_i(mode_i), .base_addr_i(base_addr_i),
    .word_count_i(word_count_i), .seed_i(seed_i),
    .stop_on_fail_i(stop_on_fail_i), .mem(mif),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_count_o(err_count_o), .fail_addr_o(fail_addr_o),
    .fail_expected_o(fail_expected_o), .fail_actual_o(fail_actual_o),
    .timeout_o(timeout_o), .leds_o(leds_o)
  );

  typedef struct {
    bit          we;
    logic [10:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic        pass;
    logic [31:0] err;
    logic [10:0] faddr;
    logic [31:0] fexp;
    logic [31:0] fact;
    logic        tmo;
    logic [7:0]  leds;
    logic [31:0] nrd;
  } res_t;

  req_t exp_req[$];
  res_t exp_res[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Memory model: completes each request three negedges after it appears.
  logic [31:0] mem_arr [0:2047];
  logic        mdone = 1'b0;
  logic [31:0] mrdata = '0;
  bit          hang = 1'b0;
  bit          corrupt_en = 1'b0;
  logic [10:0] corrupt_addr = '0;
  int          lat = 0;
  assign mif.mem_done  = mdone;
  assign mif.mem_rdata = mrdata;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mdone = 1'b0;
      lat = 0;
    end else if (mdone) begin
      mdone = 1'b0;
    end else if (mif.mem_req) begin
      lat++;
      if (lat == 3 && !hang) begin
        lat = 0;
        if (mif.mem_we) mem_arr[mif.mem_addr] = mif.mem_wdata;
        else mrdata = mem_arr[mif.mem_addr] ^
               ((corrupt_en && mif.mem_addr == corrupt_addr) ? 32'd1 : 32'd0);
        mdone = 1'b1;
      end
    end else begin
      lat = 0;
    end
  end

  function automatic logic [31:0] pat(int mode, int i, logic [10:0] a,
                                      logic [31:0] seed);
    case (mode)
      0:       return seed;
      1:       return seed + 32'(i);
      2:       return 32'd1 << (i % 32);
      default: return {21'd0, a} ^ seed;
    endcase
  endfunction

  task automatic expect_run(int mode, int base, int cnt, logic [31:0] seed,
                            bit stop, bit cen, logic [10:0] caddr, bit hng);
    res_t e;
    req_t r;
    logic [10:0] a;
    logic [31:0] p, act;
    bit wrdone;
    e.pass = 0; e.err = 0; e.faddr = 0; e.fexp = 0; e.fact = 0;
    e.tmo = 0; e.nrd = 0;
    wrdone = 0;
    if (hng) begin
      a = 11'(base);
      r.we = 1; r.addr = a; r.data = pat(mode, 0, a, seed);
      exp_req.push_back(r);
      e.tmo = 1;
    end else begin
      wrdone = (cnt > 0);
      for (int i = 0; i < cnt; i++) begin
        a = 11'((base + i) % 2048);
        r.we = 1; r.addr = a; r.data = pat(mode, i, a, seed);
        exp_req.push_back(r);
      end
      for (int i = 0; i < cnt; i++) begin
        a = 11'((base + i) % 2048);
        p = pat(mode, i, a, seed);
        r.we = 0; r.addr = a; r.data = 0;
        exp_req.push_back(r);
        e.nrd++;
        act = p ^ ((cen && a == caddr) ? 32'd1 : 32'd0);
        if (act != p) begin
          if (e.err == 0) begin e.faddr = a; e.fexp = p; e.fact = act; end
          e.err++;
          if (stop) break;
        end
      end
    end
    e.pass = (e.err == 0) && !e.tmo;
    e.leds = {e.pass, e.tmo, e.err != 0, e.pass, 1'b1, 1'b0, wrdone, 1'b0};
    exp_res.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or done.
  bit          req_prev = 0;
  int          nrd = 0;
  bit          led_pend = 0;
  logic [7:0]  led_exp = '0;
  always @(negedge clk) begin
    req_t r;
    res_t e;
    if (rst) begin
      req_prev = 0; nrd = 0; led_pend = 0;
    end else begin
      if (led_pend) begin
        chk("leds", 64'(leds_o), 64'(led_exp));
        led_pend = 0;
      end
      if (mif.mem_req && !req_prev) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_req", 64'(mif.mem_addr), 64'hFFFF_FFFF);
        end else begin
          r = exp_req.pop_front();
          chk("req_we", 64'(mif.mem_we), 64'(r.we));
          chk("req_addr", 64'(mif.mem_addr), 64'(r.addr));
          if (r.we) chk("req_wdata", 64'(mif.mem_wdata), 64'(r.data));
        end
        if (!mif.mem_we) nrd++;
      end
      req_prev = mif.mem_req;
      if (done_o) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_done", 64'(done_o), 64'(0));
        end else begin
          e = exp_res.pop_front();
          chk("pass", 64'(pass_o), 64'(e.pass));
          chk("err_count", 64'(err_count_o), 64'(e.err));
          chk("fail_addr", 64'(fail_addr_o), 64'(e.faddr));
          chk("fail_expected", 64'(fail_expected_o), 64'(e.fexp));
          chk("fail_actual", 64'(fail_actual_o), 64'(e.fact));
          chk("timeout", 64'(timeout_o), 64'(e.tmo));
          chk("read_count", 64'(nrd), 64'(e.nrd));
          chk("req_queue_drained", 64'(exp_req.size()), 64'(0));
          led_exp = e.leds;
          led_pend = 1;
        end
        nrd = 0;
      end
    end
  end

  task automatic run(int mode, int base, int cnt, logic [31:0] seed,
                     bit stop, bit cen, logic [10:0] caddr, bit hng,
                     bit glitch);
    int n;
    int len;
    expect_run(mode, base, cnt, seed, stop, cen, caddr, hng);
    corrupt_en = cen; corrupt_addr = caddr; hang = hng;
    @(negedge clk);
    mode_i = 2'(mode); base_addr_i = 11'(base); word_count_i = 12'(cnt);
    seed_i = seed; stop_on_fail_i = stop; go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    mode_i = 2'($urandom); base_addr_i = 11'($urandom);
    word_count_i = 12'($urandom); seed_i = $urandom;
    stop_on_fail_i = 1'($urandom);
    if (hng) begin
      len = 0;
      while (mif.mem_req && len < 100) begin
        len++;
        @(negedge clk);
      end
      chk("timeout_req_len", 64'(len), 64'(16));
    end
    n = 0;
    while (!done_o && n < 5000) begin
      go_i = (glitch && n == 6);
      @(negedge clk);
      n++;
    end
    go_i = 1'b0;
    chk("done_seen", 64'(done_o), 64'(1));
    if (cnt == 0) chk("zero_count_latency", 64'(n), 64'(0));
    @(negedge clk);
    @(negedge clk);
    hang = 0;
  endtask

  task automatic abort_in_read();
    int n;
    expect_run(1, 'h300, 12, 32'h1234_0000, 0, 0, 0, 0);
    @(negedge clk);
    mode_i = 2'd1; base_addr_i = 11'h300; word_count_i = 12'd12;
    seed_i = 32'h1234_0000; go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    n = 0;
    while (!(mif.mem_req && !mif.mem_we) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_read_phase", 64'(mif.mem_req && !mif.mem_we), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("abort_req", 64'(mif.mem_req), 64'(0));
    chk("abort_busy", 64'(busy_o), 64'(0));
    chk("abort_leds", 64'(leds_o), 64'(0));
    chk("abort_done", 64'(done_o), 64'(0));
    exp_req.delete();
    exp_res.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cnt, base, caddr;
    #12;
    chk("rst_req", 64'(mif.mem_req), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_pass", 64'(pass_o), 64'(0));
    chk("rst_err", 64'(err_count_o), 64'(0));
    chk("rst_timeout", 64'(timeout_o), 64'(0));
    chk("rst_leds", 64'(leds_o), 64'(0));
    chk("rst_fail_addr", 64'(fail_addr_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(1, 'h005, 4, 32'hA5A5_A5A5, 0, 0, 0, 0, 0);
    run(3, 'h7FE, 4, 32'h0, 0, 0, 0, 0, 0);
    run(0, 'h005, 4, 32'hA5A5_A5A5, 0, 1, 11'h006, 0, 0);
    run(0, 'h005, 4, 32'hA5A5_A5A5, 1, 1, 11'h006, 0, 0);
    run(1, 'h100, 4, 32'h55, 0, 0, 0, 1, 0);
    run(2, 'h010, 0, 32'h77, 0, 0, 0, 0, 0);
    run(2, 'h7F0, 40, 32'h0, 0, 0, 0, 0, 0);
    abort_in_read();
    run(1, 'h020, 10, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);

    for (int k = 0; k < 20; k++) begin
      cnt = 1 + int'($urandom_range(23));
      base = int'($urandom_range(2047));
      caddr = (base + int'($urandom_range(cnt - 1))) % 2048;
      run(int'($urandom_range(3)), base, cnt, $urandom, 1'($urandom),
          1'($urandom), 11'(caddr), 0, cnt >= 2 && $urandom_range(1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
